// File: rtl/display_scan_ctrl.sv
// Time-multiplexed six-digit scan controller feeding one shared BCD-to-7-segment decoder.
// Each slot is GUARD dark cycles followed by the selected digit lit for the rest of the slot.
module display_scan_ctrl #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int SCAN_HZ  = 6_000,
    parameter int GUARD    = 4,
    parameter int BLINK_HZ = 2,
    parameter int N_DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scan_enable,
    input  logic [4*N_DIGITS-1:0] scan_digits_in,
    input  logic [N_DIGITS-1:0]   scan_blink_mask,
    input  logic                  scan_blank_lz,
    input  logic                  scan_colon_en,
    output logic [3:0]            scan_bcd_out,
    output logic [N_DIGITS-1:0]   scan_anode_n,
    output logic                  scan_dp_n,
    output logic                  scan_frame_start
);

    localparam int DIV       = CLK_HZ / SCAN_HZ;
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int SLOT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IDX_W     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(DIV - 1);
    localparam logic [SLOT_W-1:0]  GUARD_LAST = SLOT_W'(GUARD - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_DIGITS - 1);
    localparam logic [3:0]         CODE_BLANK = 4'hF;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_GUARD = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic                  phase_q, phase_d;
    logic [4*N_DIGITS-1:0] snap_digits_q, snap_digits_d;
    logic [N_DIGITS-1:0]   snap_mask_q, snap_mask_d;
    logic                  snap_lz_q, snap_lz_d;
    logic                  snap_colon_q, snap_colon_d;
    logic [3:0]            bcd_q, bcd_d;
    logic [N_DIGITS-1:0]   anode_n_q, anode_n_d;
    logic                  dp_n_q, dp_n_d;
    logic                  frame_start_q, frame_start_d;
    logic                  load_snap;
    logic [N_DIGITS-1:0]   lz_blank;

    // A digit is suppressed when it and every more-significant digit are zero; digit 0 always shows.
    function automatic logic [N_DIGITS-1:0] calc_lz_blank(
        input logic [4*N_DIGITS-1:0] digits,
        input logic                  enable
    );
        logic all_zero;
        calc_lz_blank = '0;
        all_zero      = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            all_zero         = all_zero & (digits[4*i +: 4] == 4'd0);
            calc_lz_blank[i] = enable & all_zero;
        end
    endfunction

    assign lz_blank = calc_lz_blank(snap_digits_q, snap_lz_q);

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        idx_d         = idx_q;
        blink_cnt_d   = blink_cnt_q + 1'b1;
        phase_d       = phase_q;
        snap_digits_d = snap_digits_q;
        snap_mask_d   = snap_mask_q;
        snap_lz_d     = snap_lz_q;
        snap_colon_d  = snap_colon_q;
        frame_start_d = 1'b0;
        load_snap     = 1'b0;

        // Blink phase free-runs regardless of scanning so the rate stays steady across enables.
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end

        if (!scan_enable) begin
            state_d = ST_OFF;
            slot_d  = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d   = ST_GUARD;
                    slot_d    = '0;
                    idx_d     = '0;
                    load_snap = 1'b1;
                end
                ST_GUARD: begin
                    slot_d = slot_q + 1'b1;
                    if (slot_q == GUARD_LAST) begin
                        state_d = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (slot_q == SLOT_LAST) begin
                        slot_d  = '0;
                        state_d = ST_GUARD;
                        if (idx_q == IDX_LAST) begin
                            idx_d     = '0;
                            load_snap = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    slot_d  = '0;
                    idx_d   = '0;
                end
            endcase
        end

        if (load_snap) begin
            snap_digits_d = scan_digits_in;
            snap_mask_d   = scan_blink_mask;
            snap_lz_d     = scan_blank_lz;
            snap_colon_d  = scan_colon_en;
            frame_start_d = 1'b1;
        end

        // Outputs are computed from next-state values so the registered pins line up with the state.
        bcd_d     = CODE_BLANK;
        anode_n_d = '1;
        dp_n_d    = 1'b1;
        if (state_d == ST_SHOW) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (idx_d == IDX_W'(i)) begin
                    anode_n_d[i] = 1'b0;
                    if (lz_blank[i] || (snap_mask_q[i] && phase_d)) begin
                        bcd_d = CODE_BLANK;
                    end else begin
                        bcd_d = snap_digits_q[4*i +: 4];
                    end
                end
            end
            dp_n_d = ~(snap_colon_q && ((idx_d == IDX_W'(2)) || (idx_d == IDX_W'(4))));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_OFF;
            slot_q        <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            phase_q       <= 1'b0;
            snap_digits_q <= '0;
            snap_mask_q   <= '0;
            snap_lz_q     <= 1'b0;
            snap_colon_q  <= 1'b0;
            bcd_q         <= CODE_BLANK;
            anode_n_q     <= '1;
            dp_n_q        <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            phase_q       <= phase_d;
            snap_digits_q <= snap_digits_d;
            snap_mask_q   <= snap_mask_d;
            snap_lz_q     <= snap_lz_d;
            snap_colon_q  <= snap_colon_d;
            bcd_q         <= bcd_d;
            anode_n_q     <= anode_n_d;
            dp_n_q        <= dp_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign scan_bcd_out     = bcd_q;
    assign scan_anode_n     = anode_n_q;
    assign scan_dp_n        = dp_n_q;
    assign scan_frame_start = frame_start_q;

endmodule
